branch_fetch_ctrl: RTL

Fetch-side consumer of the ID-stage branch decision in the five-stage pipelined MIPS core. Owns the PC register and the IF/ID pipeline register; takes the comparator's `Branch` bit, jump requests and stage-destination info, and decides each cycle whether to advance, redirect (flushing the wrong-path fetch) or stall (inserting an ID/EX bubble). Sits between the instruction memory and the ID stage.

---
 rtl/branch_fetch_ctrl_pkg.sv | 13 +
 rtl/branch_hazard_detect.sv | 39 +++
 rtl/branch_fetch_ctrl.sv | 90 +++++++++
 3 files changed

// File: rtl/branch_fetch_ctrl_pkg.sv
// Shared constants and FSM encoding for the fetch-side
// branch/jump redirect and hazard-stall control.
package branch_fetch_ctrl_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

  typedef enum logic {
    RUN   = 1'b0,
    WAIT1 = 1'b1
  } state_t;

endpackage

// File: rtl/branch_hazard_detect.sv
// Combinational detection of RAW hazards on the operands
// a branch or jump consumes while resolving in ID.
module branch_hazard_detect
  import branch_fetch_ctrl_pkg::*;
(
  input  logic       IsBranch,
  input  logic       Jump,
  input  logic [4:0] IdRs,
  input  logic [4:0] IdRt,
  input  logic       ExRegWrite,
  input  logic       ExMemRead,
  input  logic [4:0] ExDst,
  input  logic       MemMemRead,
  input  logic [4:0] MemDst,
  output logic       haz_ex2,
  output logic       haz_ex1,
  output logic       haz_mem
);

  logic active;
  logic ex_hit;
  logic mem_hit;

  assign active = IsBranch | Jump;

  // rt only matters for beq/bne; $0 never creates a dependency
  assign ex_hit = active & (ExDst != 5'd0) &
                  ((IdRs == ExDst) |
                   (IsBranch & (IdRt == ExDst)));

  assign mem_hit = active & (MemDst != 5'd0) &
                   ((IdRs == MemDst) |
                    (IsBranch & (IdRt == MemDst)));

  assign haz_ex2 = ExMemRead & ex_hit;
  assign haz_ex1 = ExRegWrite & ~ExMemRead & ex_hit;
  assign haz_mem = MemMemRead & mem_hit;

endmodule

// File: rtl/branch_fetch_ctrl.sv
// PC and IF/ID register owner: advances, redirects on
// taken branch/jump, or stalls on operand hazards.
module branch_fetch_ctrl
  import branch_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] InstrIn,
  input  logic        Branch,
  input  logic        IsBranch,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  input  logic [4:0]  IdRs,
  input  logic [4:0]  IdRt,
  input  logic        ExRegWrite,
  input  logic        ExMemRead,
  input  logic [4:0]  ExDst,
  input  logic        MemMemRead,
  input  logic [4:0]  MemDst,
  output logic [31:0] PC,
  output logic [31:0] IfIdPc4,
  output logic [31:0] IfIdInstr,
  output logic        Stall,
  output logic        IdExBubble
);

  state_t      state;
  logic        haz_ex2;
  logic        haz_ex1;
  logic        haz_mem;
  logic [31:0] pc4;

  branch_hazard_detect u_haz (
    .IsBranch   (IsBranch),
    .Jump       (Jump),
    .IdRs       (IdRs),
    .IdRt       (IdRt),
    .ExRegWrite (ExRegWrite),
    .ExMemRead  (ExMemRead),
    .ExDst      (ExDst),
    .MemMemRead (MemMemRead),
    .MemDst     (MemDst),
    .haz_ex2    (haz_ex2),
    .haz_ex1    (haz_ex1),
    .haz_mem    (haz_mem)
  );

  assign pc4        = PC + 32'd4;
  assign Stall      = haz_ex2 | haz_ex1 | haz_mem |
                      (state == WAIT1);
  assign IdExBubble = Stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     state <= haz_ex2 ? WAIT1 : RUN;
        WAIT1:   state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  // Redirects squash the sequential fetch: no delay slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PC        <= RESET_PC;
      IfIdPc4   <= 32'd0;
      IfIdInstr <= NOP_INSTR;
    end else if (!Stall) begin
      IfIdPc4 <= pc4;
      if (Jump) begin
        PC        <= JumpTarget;
        IfIdInstr <= NOP_INSTR;
      end else if (IsBranch && Branch) begin
        PC        <= BranchTarget;
        IfIdInstr <= NOP_INSTR;
      end else begin
        PC        <= pc4;
        IfIdInstr <= InstrIn;
      end
    end
  end

endmodule
